// File: rtl/stream_demux1to3_pkg.sv
// ============================================================================
// Module      : stream_demux1to3_pkg
// Description : Shared route encoding and select decode for the 1-to-3 demux
//               and its 3-to-1 source-select counterpart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_demux1to3_pkg;

  localparam int ROUTE_W = 2;

  typedef enum logic [ROUTE_W-1:0] {
    ROUTE_1 = 2'd1,
    ROUTE_2 = 2'd2,
    ROUTE_3 = 2'd3
  } route_t;

  // Bit 1 dominates so that 2'b11 lands on destination 3, matching the mux side.
  function automatic route_t decode_route(input logic [ROUTE_W-1:0] sel);
    if (sel[1]) begin
      return ROUTE_3;
    end else if (sel[0]) begin
      return ROUTE_2;
    end else begin
      return ROUTE_1;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux1to3_if.sv
// ============================================================================
// Module      : stream_demux1to3_if
// Description : Request stream, three destination streams and debug counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_demux1to3_if
  import stream_demux1to3_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic [ROUTE_W-1:0]    control_signal;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_data;

  logic                  o_valid_1;
  logic                  o_valid_2;
  logic                  o_valid_3;
  logic                  i_ready_1;
  logic                  i_ready_2;
  logic                  i_ready_3;
  logic [DATA_WIDTH-1:0] o_data_1;
  logic [DATA_WIDTH-1:0] o_data_2;
  logic [DATA_WIDTH-1:0] o_data_3;

  logic [CNT_WIDTH-1:0]  o_cnt_1;
  logic [CNT_WIDTH-1:0]  o_cnt_2;
  logic [CNT_WIDTH-1:0]  o_cnt_3;

  modport slave (
    input  control_signal, i_valid, i_data,
    input  i_ready_1, i_ready_2, i_ready_3,
    output o_ready,
    output o_valid_1, o_valid_2, o_valid_3,
    output o_data_1, o_data_2, o_data_3,
    output o_cnt_1, o_cnt_2, o_cnt_3
  );

  modport master (
    output control_signal, i_valid, i_data,
    output i_ready_1, i_ready_2, i_ready_3,
    input  o_ready,
    input  o_valid_1, o_valid_2, o_valid_3,
    input  o_data_1, o_data_2, o_data_3,
    input  o_cnt_1, o_cnt_2, o_cnt_3
  );

endinterface

`default_nettype wire

// File: rtl/stream_demux_cnt.sv
// ============================================================================
// Module      : stream_demux_cnt
// Description : Wrapping transfer counter with synchronous clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_en,
  output logic      [CNT_WIDTH-1:0] o_cnt
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/stream_demux1to3.sv
// ============================================================================
// Module      : stream_demux1to3
// Description : Registered 1-to-3 stream demultiplexer with per-destination
//               completed-transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux1to3
  import stream_demux1to3_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic           clk,
  input  wire logic           arst,
  stream_demux1to3_if.slave   bus
);

  logic                  r_full;
  route_t                r_dest;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_dest_ready;
  logic w_out_fire;
  logic w_in_fire;
  logic w_ready;
  logic w_sel_1;
  logic w_sel_2;
  logic w_sel_3;

  assign w_sel_1 = (r_dest == ROUTE_1);
  assign w_sel_2 = (r_dest == ROUTE_2);
  assign w_sel_3 = (r_dest == ROUTE_3);

  // Only the addressed consumer's ready matters; the others are ignored.
  always_comb begin
    w_dest_ready = 1'b0;
    case (r_dest)
      ROUTE_1: w_dest_ready = bus.i_ready_1;
      ROUTE_2: w_dest_ready = bus.i_ready_2;
      ROUTE_3: w_dest_ready = bus.i_ready_3;
      default: w_dest_ready = 1'b0;
    endcase
  end

  assign w_out_fire = r_full && w_dest_ready;
  assign w_ready    = !arst && (!r_full || w_out_fire);
  assign w_in_fire  = bus.i_valid && w_ready;

  // A load wins over a drain so back-to-back beats never leave a bubble.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_full <= 1'b0;
      r_dest <= ROUTE_1;
      r_data <= '0;
    end else if (w_in_fire) begin
      r_full <= 1'b1;
      r_dest <= decode_route(bus.control_signal);
      r_data <= bus.i_data;
    end else if (w_out_fire) begin
      r_full <= 1'b0;
    end
  end

  assign bus.o_ready   = w_ready;

  assign bus.o_valid_1 = r_full && w_sel_1;
  assign bus.o_valid_2 = r_full && w_sel_2;
  assign bus.o_valid_3 = r_full && w_sel_3;

  assign bus.o_data_1  = w_sel_1 ? r_data : '0;
  assign bus.o_data_2  = w_sel_2 ? r_data : '0;
  assign bus.o_data_3  = w_sel_3 ? r_data : '0;

  stream_demux_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_1 (
    .clk   (clk),
    .rst   (arst),
    .i_en  (w_out_fire && w_sel_1),
    .o_cnt (bus.o_cnt_1)
  );

  stream_demux_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_2 (
    .clk   (clk),
    .rst   (arst),
    .i_en  (w_out_fire && w_sel_2),
    .o_cnt (bus.o_cnt_2)
  );

  stream_demux_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_3 (
    .clk   (clk),
    .rst   (arst),
    .i_en  (w_out_fire && w_sel_3),
    .o_cnt (bus.o_cnt_3)
  );

endmodule

`default_nettype wire

// File: doc/stream_demux1to3.md
Name: stream_demux1to3

Overview:
- Registered 1-to-3 stream demultiplexer, the write-side counterpart of the core's 3-to-1 source-select mux.
- Takes one valid/ready request stream carrying a 2-bit route select and steers each beat to exactly one of three consumers (e.g. ALU result path, load/store unit, CSR/writeback path).
- One pipeline stage: one holding register with full throughput, plus per-destination completed-transfer counters for debug and performance.

Parameters:
- DATA_WIDTH, 32, width of the payload.
- CNT_WIDTH, 16, width of each per-destination transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst  input  1  reset, synchronous and active-high.
- control_signal  input  2  route select for the input beat; decode below.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept the input beat this cycle.
- i_data  input  DATA_WIDTH  input payload.
- o_valid_1 / o_valid_2 / o_valid_3  output  1 each  beat valid toward destination 1/2/3.
- i_ready_1 / i_ready_2 / i_ready_3  input  1 each  destination 1/2/3 accepts the beat.
- o_data_1 / o_data_2 / o_data_3  output  DATA_WIDTH each  payload toward destination 1/2/3.
- o_cnt_1 / o_cnt_2 / o_cnt_3  output  CNT_WIDTH each  completed output handshakes per destination.

Behaviour:
- Route decode, priority identical to the source-select mux:
  - control_signal[1]=1 -> dest 3 (covers 2'b10 and 2'b11).
  - else control_signal[0]=1 -> dest 2.
  - else -> dest 1.
- State:
  - full flag (1 bit).
  - dest register (2-bit encoded route, values 1..3).
  - data register (DATA_WIDTH).
  - three counters (CNT_WIDTH each).
- Reset: while arst=1 at a clock edge:
  - full <= 0, dest <= dest 1, data <= 0, all counters <= 0.
  - Any buffered beat is discarded, and the discard is not counted.
  - o_ready = 0 combinationally whenever arst=1.
- Output handshake:
  - out_fire = full && i_ready_k, where k = dest.
  - o_valid_k = full && (dest==k).
  - At most one o_valid_* is high in any cycle.
- Input handshake:
  - o_ready = !arst && (!full || out_fire). o_ready is combinational from state and i_ready_k.
  - in_fire = i_valid && o_ready.
- Data outputs:
  - o_data_k = data when dest==k, else all-zero.
  - Payload and dest are stable while o_valid_k=1 and i_ready_k=0.
- Latency: a beat accepted in cycle N is presented in cycle N+1.
- Throughput: one beat per cycle sustained while the addressed consumer is ready.
- Next state:
  - in_fire: full <= 1, dest/data <= decoded input, regardless of out_fire. This covers simultaneous drain and load with no bubble, including a change of destination.
  - out_fire && !in_fire: full <= 0; dest/data hold their values.
  - neither: hold.
- Counters:
  - cnt_k <= cnt_k + 1 on out_fire with dest==k.
  - Wrap modulo 2^CNT_WIDTH; no saturation.
  - Counters are not cleared except by reset.
- Backpressure:
  - When full and the addressed consumer is not ready, o_ready=0 even if other consumers are ready. No reordering and no bypass around a stalled head beat.
- Boundary rules:
  - i_valid=0 has no effect.
  - Changing control_signal/i_data while i_valid=1 and o_ready=0 is legal; the value sampled at the in_fire edge is used.
  - i_ready_* of non-addressed destinations is ignored.
- No X propagation from the data register after reset.

Decomposition:
- Shared package holds:
  - typedef route_t, a 2-bit enum ROUTE_1=2'd1, ROUTE_2=2'd2, ROUTE_3=2'd3.
  - function decode_route(logic [1:0] sel) -> route_t, reused by the mux-side control logic so both ends of the interface share one decode.
- One natural sub-module: stream_demux_cnt, a CNT_WIDTH wrapping counter with synchronous active-high clear and increment enable, instantiated three times.
- Holding register and handshake logic stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: arst=1 for 2 cycles, then 0, i_valid=0.
  - Required: all o_valid_*=0, o_data_*=0, o_cnt_*=0; o_ready=0 during reset and 1 after.
- Route decode:
  - Stimulus: 4 beats with all i_ready_*=1: control_signal=00/01/10/11, data 0xA0/0xA1/0xA2/0xA3.
  - Required: one cycle later each, 0xA0 on dest 1, 0xA1 on dest 2, 0xA2 and 0xA3 on dest 3.
  - Final counts: cnt_1=1, cnt_2=1, cnt_3=2.
- Sustained throughput:
  - Stimulus: 8 back-to-back beats to dest 2 with i_ready_2=1.
  - Required: o_valid_2 high 8 consecutive cycles, o_ready=1 throughout, cnt_2=8.
- Head-of-line stall:
  - Stimulus: beat 0x55 to dest 1 with i_ready_1=0 for 5 cycles and i_ready_2=1, next beat targets dest 2.
  - Required: o_valid_1 and o_data_1=0x55 held for 5 cycles, o_ready=0, dest 2 sees nothing until dest 1 accepts.
- Simultaneous drain/load with destination change:
  - Stimulus: full with dest 3 (0x11), i_ready_3=1, same-cycle input 0x22 to dest 1.
  - Required: next cycle o_valid_3=0, o_valid_1=1 with data 0x22, cnt_3 incremented by 1.
- Mid-operation reset and counter wrap:
  - Stimulus (wrap): CNT_WIDTH=4, 17 beats to dest 1.
  - Required (wrap): cnt_1=1.
  - Stimulus (reset): assert arst while full with an unaccepted beat.
  - Required (reset): next cycle full=0, all o_valid_*=0, counters 0, discarded beat never appears.
